bcd_count_ctrl: RTL and testbench
=================================

# bcd_count_ctrl

Sequencing controller for the three-digit BCD counting datapath: holds a 12-bit packed-BCD count (000–999) and advances it by one at a prescaled rate under start/stop/clear control. It detects overflow at 999 and latches it, and time-multiplexes the three digits onto a single nibble bus for a scanned display. It sits between front-panel control pulses and the display driver.

## Interface
- `TICK_DIV`, default 50000: clock cycles per count increment while running; legal range ≥1.
- `SCAN_DIV`, default 1000: clock cycles per display digit step; legal range ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low; one clock domain only.
- `start`  in  1  synchronous single-cycle pulse; run or resume.
- `stop`  in  1  synchronous single-cycle pulse; pause.
- `clear`  in  1  synchronous single-cycle pulse; zero the count and return to idle.
- `count_o`  out  12  registered packed BCD count, [11:8] hundreds, [7:4] tens, [3:0] units.
- `run_o`  out  1  high while in RUN.
- `ovf_o`  out  1  high while in OVF.
- `digit_sel`  out  3  one-hot digit enable, active-high; bit0 units, bit1 tens, bit2 hundreds.
- `digit_bcd`  out  4  BCD value of the digit currently selected.

## Operation
- States: IDLE, RUN, PAUSE, OVF. Input priority in every state: clear > stop > start.
- `clear` (any state): go to IDLE; count = 0x000; prescaler = 0.
- IDLE: `start` without `stop` → RUN. Otherwise remain in IDLE. The prescaler is held at 0.
- RUN:
  - `stop` → PAUSE. The prescaler freezes at its current value and no increment occurs that cycle, even if the prescaler is at its terminal value.
  - Otherwise the prescaler counts 0..TICK_DIV-1 and wraps.
  - On a cycle where the prescaler equals TICK_DIV-1:
    - If count ≠ 0x999: count takes its BCD increment.
    - If count = 0x999: go to OVF; count holds 0x999.
- BCD increment rule:
  - The units digit increments; a units digit of 9 becomes 0 and carries into tens.
  - Tens carries into hundreds in the same way.
  - The count never holds a non-BCD nibble and never exceeds 0x999.
- PAUSE: `start` without `stop` → RUN, keeping the frozen prescaler value. `stop` alone is ignored.
- OVF: `start` and `stop` are ignored; only `clear` exits. The count holds 0x999.
- Display scan:
  - A scan counter runs freely in every state and is affected only by `rst_n`.
  - Every SCAN_DIV cycles, `digit_sel` rotates 001 → 010 → 100 → 001.
  - `digit_bcd` is registered together with `digit_sel` and always equals the count nibble for the newly selected digit, taken from the count value current at that edge.

## Timing
- Reset values: `count_o` = 0x000, `run_o` = 0, `ovf_o` = 0, `digit_sel` = 3'b001, `digit_bcd` = 0. The state is IDLE and both the prescaler and the scan counter are 0.
- Reset asserted mid-run takes effect immediately, with no clock required. After release, the first edge behaves as IDLE.
- `start` sampled at edge N: `run_o` is high after edge N.
- After entering RUN from IDLE, the first increment is visible after the TICK_DIV-th RUN edge. Later increments follow every TICK_DIV RUN cycles.
- The transition into OVF and `ovf_o` high are visible after the terminal edge that finds count = 0x999.
- A `clear` sampled at edge N produces the zero count and IDLE state after edge N, and drops `run_o` and `ovf_o` after the same edge.
- `digit_sel` changes on every SCAN_DIV-th edge. `digit_bcd` updates on the same edge; it does not track count changes between scan steps.

## Test plan
- Reset: hold `rst_n` low, toggle inputs → all outputs at reset values; `digit_sel` = 001.
- Count (TICK_DIV=4): start pulse, then 40 RUN cycles → `count_o` = 0x010, `run_o` = 1.
- Carry chain (TICK_DIV=1): 100 RUN cycles → 0x100. 999 RUN cycles → 0x999, then one more → OVF: `ovf_o` = 1, `count_o` = 0x999. A start pulse is ignored. A clear pulse → 0x000, IDLE.
- Pause/resume (TICK_DIV=4):
  - Stop pulse after 6 RUN cycles → `count_o` = 0x001 holds for 20 cycles.
  - Start pulse, then 2 more cycles → 0x002.
  - Stop pulse coincident with the terminal prescaler value → no increment.
- Simultaneous events: start and stop together in IDLE → stays IDLE. Clear and start together in RUN → IDLE, 0x000.
- Scan (SCAN_DIV=2, count 0x123 held in PAUSE): over 6 cycles, `digit_sel`/`digit_bcd` cycle 001/3 → 010/2 → 100/1 → 001/3.

Source files
------------

// File: rtl/bcd_count_ctrl_if.sv
// Control-pulse and display bus between the front panel, the BCD counter and the scanned display.
interface bcd_count_ctrl_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic [11:0] count_o;
    logic        run_o;
    logic        ovf_o;
    logic [2:0]  digit_sel;
    logic [3:0]  digit_bcd;

    modport master (
        output start, stop, clear,
        input  count_o, run_o, ovf_o, digit_sel, digit_bcd
    );

    modport slave (
        input  start, stop, clear,
        output count_o, run_o, ovf_o, digit_sel, digit_bcd
    );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Three-digit BCD counter sequencer: start/stop/clear control, prescaled increment,
// overflow latch at 999, and a free-running one-hot digit scan for a multiplexed display.
module bcd_count_ctrl #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_count_ctrl_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = 12;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COUNT_MAX  = 12'h999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            run_q, ovf_q;
    logic [SW-1:0]   scan_q, scan_d;
    logic [2:0]      sel_q, sel_d;
    logic [3:0]      bcd_q, bcd_d;
    logic            go;

    // Packed-BCD +1; callers guarantee the input is below 999.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [3:0] u, t, h;
        u = v[3:0];
        t = v[7:4];
        h = v[11:8];
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {h, t, u};
    endfunction

    assign go = bus.start && !bus.stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            run_q   <= (state_d == RUN);
            ovf_q   <= (state_d == OVF);
        end
    end

    // Next-state: clear dominates everything, stop dominates start.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        if (bus.clear) begin
            state_d = IDLE;
            presc_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (go) state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (count_q == COUNT_MAX) state_d = OVF;
                        else                      count_d = bcd_inc(count_q);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (go) state_d = RUN;
                end
                OVF: begin
                    state_d = OVF;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            sel_q  <= 3'b001;
            bcd_q  <= 4'd0;
        end else begin
            scan_q <= scan_d;
            sel_q  <= sel_d;
            bcd_q  <= bcd_d;
        end
    end

    // Digit scan: rotate the one-hot select and capture that digit's nibble together.
    always_comb begin
        scan_d = scan_q + SW'(1);
        sel_d  = sel_q;
        bcd_d  = bcd_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            sel_d  = {sel_q[1:0], sel_q[2]};
            case (sel_d)
                3'b001:  bcd_d = count_q[3:0];
                3'b010:  bcd_d = count_q[7:4];
                3'b100:  bcd_d = count_q[11:8];
                default: bcd_d = 4'd0;
            endcase
        end
    end

    assign bus.count_o   = count_q;
    assign bus.run_o     = run_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.digit_sel = sel_q;
    assign bus.digit_bcd = bcd_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl: two instances (TICK_DIV=4 and TICK_DIV=1, both SCAN_DIV=2)
// driven by directed pulses; a negedge monitor pops expected outputs and compares.
module tb_bcd_count_ctrl;

    localparam int unsigned SCAN = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    bcd_count_ctrl_if ifa ();
    bcd_count_ctrl_if ifb ();

    bcd_count_ctrl #(.TICK_DIV(4), .SCAN_DIV(SCAN)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    bcd_count_ctrl #(.TICK_DIV(1), .SCAN_DIV(SCAN)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    typedef struct {
        string       name;
        int          d;
        logic [11:0] cnt;
        logic        run;
        logic        ovf;
        bit          scan;
        logic [2:0]  sel;
        logic [3:0]  bcd;
    } exp_t;

    exp_t sbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen with reset released, mirrors the free-running scan timebase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
    end

    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] a_cnt;
        logic        a_run, a_ovf;
        logic [2:0]  a_sel;
        logic [3:0]  a_bcd;
        bit          ok;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.d == 0) begin
                a_cnt = ifa.count_o; a_run = ifa.run_o; a_ovf = ifa.ovf_o;
                a_sel = ifa.digit_sel; a_bcd = ifa.digit_bcd;
            end else begin
                a_cnt = ifb.count_o; a_run = ifb.run_o; a_ovf = ifb.ovf_o;
                a_sel = ifb.digit_sel; a_bcd = ifb.digit_bcd;
            end
            ok = (a_cnt === e.cnt) && (a_run === e.run) && (a_ovf === e.ovf);
            if (e.scan) ok = ok && (a_sel === e.sel) && (a_bcd === e.bcd);
            n_checks = n_checks + 1;
            if (!ok) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got count=%h run=%b ovf=%b sel=%b bcd=%h; expected count=%h run=%b ovf=%b sel=%b bcd=%h (scan checked=%0d)",
                         e.name, a_cnt, a_run, a_ovf, a_sel, a_bcd,
                         e.cnt, e.run, e.ovf, e.sel, e.bcd, e.scan);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input logic s, input logic p, input logic c);
        if (d == 0) begin
            ifa.start = s; ifa.stop = p; ifa.clear = c;
        end else begin
            ifb.start = s; ifb.stop = p; ifb.clear = c;
        end
    endtask

    task automatic pulse(input int d, input logic s, input logic p, input logic c);
        set_in(d, s, p, c);
        tick(1);
        set_in(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input int d, input logic [11:0] c,
                              input logic r, input logic o);
        exp_t e;
        e.name = name; e.d = d; e.cnt = c; e.run = r; e.ovf = o;
        e.scan = 1'b0; e.sel = 3'b000; e.bcd = 4'd0;
        sbq.push_back(e);
    endtask

    task automatic expect_scan(input string name, input int d, input logic [11:0] c,
                               input logic r, input logic o,
                               input logic [2:0] sel, input logic [3:0] bcd);
        exp_t e;
        e.name = name; e.d = d; e.cnt = c; e.run = r; e.ovf = o;
        e.scan = 1'b1; e.sel = sel; e.bcd = bcd;
        sbq.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish; expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v123;
        int          idx;
        v123 = 12'h123;
        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0);

        // Reset held while inputs toggle.
        tick(1);
        set_in(0, 1'b1, 1'b0, 1'b0);
        set_in(1, 1'b1, 1'b1, 1'b0);
        tick(1);
        set_in(0, 1'b0, 1'b1, 1'b1);
        set_in(1, 1'b1, 1'b0, 1'b0);
        tick(1);
        set_in(0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0);
        expect_scan("reset_a", 0, 12'h000, 1'b0, 1'b0, 3'b001, 4'd0);
        expect_scan("reset_b", 1, 12'h000, 1'b0, 1'b0, 3'b001, 4'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        n_checks = n_checks + 1;
        if (ifa.digit_sel !== 3'b001 || ifb.digit_sel !== 3'b001) begin
            n_fail = n_fail + 1;
            $display("FAIL first_scan_sel: got sel_a=%b sel_b=%b; expected 001", ifa.digit_sel, ifb.digit_sel);
        end

        // Basic counting with TICK_DIV=4.
        pulse(0, 1'b1, 1'b0, 1'b0);
        expect_out("a_start_run", 0, 12'h000, 1'b1, 1'b0);
        tick(40);
        expect_out("a_count40", 0, 12'h010, 1'b1, 1'b0);
        n_checks = n_checks + 1;
        if (ifa.count_o !== 12'h010) begin
            n_fail = n_fail + 1;
            $display("FAIL a_count40_direct: got count=%h; expected 010", ifa.count_o);
        end
        pulse(0, 1'b0, 1'b0, 1'b1);
        expect_out("a_clear", 0, 12'h000, 1'b0, 1'b0);

        // Pause / resume and stop on the terminal prescaler value.
        pulse(0, 1'b1, 1'b0, 1'b0);
        tick(6);
        pulse(0, 1'b0, 1'b1, 1'b0);
        expect_out("a_pause", 0, 12'h001, 1'b0, 1'b0);
        n_checks = n_checks + 1;
        if (ifa.run_o !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL a_pause_direct: got run=%b; expected 0", ifa.run_o);
        end
        tick(20);
        expect_out("a_hold20", 0, 12'h001, 1'b0, 1'b0);
        pulse(0, 1'b1, 1'b0, 1'b0);
        tick(2);
        expect_out("a_resume", 0, 12'h002, 1'b1, 1'b0);
        tick(3);
        pulse(0, 1'b0, 1'b1, 1'b0);
        expect_out("a_stop_terminal", 0, 12'h002, 1'b0, 1'b0);
        pulse(0, 1'b1, 1'b0, 1'b0);
        tick(1);
        expect_out("a_resume_terminal", 0, 12'h003, 1'b1, 1'b0);

        // Simultaneous pulses.
        pulse(0, 1'b1, 1'b0, 1'b1);
        expect_out("a_clear_start_run", 0, 12'h000, 1'b0, 1'b0);
        pulse(0, 1'b1, 1'b1, 1'b0);
        expect_out("a_start_stop_idle", 0, 12'h000, 1'b0, 1'b0);
        tick(4);
        expect_out("a_idle_stays", 0, 12'h000, 1'b0, 1'b0);

        // Scan with 0x123 held in PAUSE.
        pulse(0, 1'b1, 1'b0, 1'b0);
        tick(492);
        expect_out("a_at_123", 0, 12'h123, 1'b1, 1'b0);
        pulse(0, 1'b0, 1'b1, 1'b0);
        tick(2);
        while ((cyc % SCAN) != 0) tick(1);
        for (int i = 0; i < 6; i++) begin
            idx = (cyc / SCAN) % 3;
            expect_scan("a_scan", 0, 12'h123, 1'b0, 1'b0, 3'(1 << idx), v123[idx*4 +: 4]);
            tick(1);
        end

        // Asynchronous reset mid-run: observed before any further clock edge.
        pulse(0, 1'b1, 1'b0, 1'b0);
        tick(3);
        rst_n = 1'b0;
        expect_scan("a_async_reset", 0, 12'h000, 1'b0, 1'b0, 3'b001, 4'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        expect_out("a_after_reset_idle", 0, 12'h000, 1'b0, 1'b0);

        // Carry chain and overflow with TICK_DIV=1.
        pulse(1, 1'b1, 1'b0, 1'b0);
        tick(100);
        expect_out("b_count100", 1, 12'h100, 1'b1, 1'b0);
        tick(899);
        expect_out("b_count999", 1, 12'h999, 1'b1, 1'b0);
        tick(1);
        expect_out("b_ovf", 1, 12'h999, 1'b0, 1'b1);
        n_checks = n_checks + 1;
        if (ifb.ovf_o !== 1'b1 || ifb.count_o !== 12'h999) begin
            n_fail = n_fail + 1;
            $display("FAIL b_ovf_direct: got ovf=%b count=%h; expected ovf=1 count=999", ifb.ovf_o, ifb.count_o);
        end
        pulse(1, 1'b1, 1'b0, 1'b0);
        expect_out("b_ovf_ignore_start", 1, 12'h999, 1'b0, 1'b1);
        pulse(1, 1'b0, 1'b1, 1'b0);
        expect_out("b_ovf_ignore_stop", 1, 12'h999, 1'b0, 1'b1);
        pulse(1, 1'b0, 1'b0, 1'b1);
        expect_out("b_ovf_clear", 1, 12'h000, 1'b0, 1'b0);
        n_checks = n_checks + 1;
        if (ifb.count_o !== 12'h000) begin
            n_fail = n_fail + 1;
            $display("FAIL b_ovf_clear_direct: got count=%h; expected 000", ifb.count_o);
        end
        pulse(1, 1'b1, 1'b0, 1'b0);
        tick(5);
        expect_out("b_count5", 1, 12'h005, 1'b1, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b1);
        expect_out("b_clear_start_run", 1, 12'h000, 1'b0, 1'b0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
